// File: rtl/vend_pkg.sv
// Shared vending definitions: FSM states, coin denominations and datapath
// widths common to the payment validator and the change dispenser.
package vend_pkg;

    localparam int PAID_W  = 5;
    localparam int PRICE_W = 4;
    localparam int CNT_W   = 4;

    localparam logic [3:0] COIN_5 = 4'd5;
    localparam logic [3:0] COIN_2 = 4'd2;
    localparam logic [3:0] COIN_1 = 4'd1;

    typedef enum logic [1:0] {
        IDLE,
        DISPENSE,
        DONE,
        ERROR
    } state_t;

endpackage

// File: rtl/coin_select.sv
// Picks the largest denomination (5, 2, 1) not exceeding the remaining change.
// Ports: rem (remaining change) in, coin (denomination) out.
module coin_select
    import vend_pkg::*;
(
    input  logic [PAID_W-1:0] rem,
    output logic [3:0]        coin
);

    always_comb begin
        coin = COIN_1;
        if (rem >= PAID_W'(5))
            coin = COIN_5;
        else if (rem >= PAID_W'(2))
            coin = COIN_2;
    end

endmodule

// File: rtl/change_dispenser.sv
// Computes change = paid - price and hands it to the coin hopper one coin at a
// time over a valid/ack handshake, largest denomination first.
// Ports: clk, rst (async high); start/paid/price from the vending FSM;
//   coin_valid/coin_value/coin_ack to the hopper; busy/done/err/coin_count status.
module change_dispenser
    import vend_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [PAID_W-1:0]  paid,
    input  logic [PRICE_W-1:0] price,
    input  logic               coin_ack,
    output logic               coin_valid,
    output logic [3:0]         coin_value,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [CNT_W-1:0]   coin_count
);

    state_t             state;
    state_t             next;
    logic [PAID_W-1:0]  rem;
    logic [PAID_W-1:0]  rem_d;
    logic [CNT_W-1:0]   cnt_d;
    logic [PAID_W:0]    diff;
    logic [3:0]         coin;

    // Extra top bit of diff is the borrow: set when paid < price.
    assign diff = {1'b0, paid} - (PAID_W+1)'(price);

    coin_select u_coin_select (
        .rem  (rem),
        .coin (coin)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            rem        <= '0;
            coin_count <= '0;
        end else begin
            state      <= next;
            rem        <= rem_d;
            coin_count <= cnt_d;
        end
    end

    always_comb begin
        next       = state;
        rem_d      = rem;
        cnt_d      = coin_count;
        coin_valid = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    cnt_d = '0;
                    if (diff[PAID_W])
                        next = ERROR;
                    else if (diff == '0)
                        next = DONE;
                    else begin
                        rem_d = diff[PAID_W-1:0];
                        next  = DISPENSE;
                    end
                end
            end
            DISPENSE: begin
                coin_valid = 1'b1;
                if (coin_ack) begin
                    rem_d = rem - PAID_W'(coin);
                    cnt_d = coin_count + CNT_W'(1);
                    if (rem_d == '0)
                        next = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                next = IDLE;
            end
            ERROR: begin
                done = 1'b1;
                err  = 1'b1;
                next = IDLE;
            end
            default: next = IDLE;
        endcase
    end

    // Outputs derive from the state register, so an async reset
    // withdraws the presented coin immediately.
    assign busy       = (state != IDLE);
    assign coin_value = coin_valid ? coin : 4'd0;

endmodule
